// File: rtl/ip_codma_rd_engine_pkg.sv
// Shared types and constants for the codma read datapath.
// Pure declarations: no logic, no latency, no flow control.
package ip_codma_pkg;

    localparam int CODMA_WORD_W = 32;

    typedef enum logic [2:0] {
        RD_IDLE    = 3'd0,
        RD_ASK     = 3'd1,
        RD_GRANTED = 3'd2,
        RD_DONE    = 3'd3,
        RD_ERR     = 3'd4
    } rd_eng_state_t;

    // Words carried by one bus beat for a given bus/word width pairing.
    function automatic int beat_words(input int data_w, input int word_w);
        return data_w / word_w;
    endfunction

endpackage

// File: rtl/ip_codma_rd_engine_if.sv
// Memory read-bus bundle between the codma read engine (master) and the memory side (slave).
// Wires only; request/grant handshake, beats accepted unconditionally by the engine.
interface ip_codma_rd_engine_if #(
    parameter int DATA_W = 64
);
    logic              bus_req;
    logic              bus_grant;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;
    logic              bus_error;

    modport master (
        output bus_req,
        input  bus_grant,
        input  bus_rvalid,
        input  bus_rdata,
        input  bus_error
    );

    modport slave (
        input  bus_req,
        output bus_grant,
        output bus_rvalid,
        output bus_rdata,
        output bus_error
    );
endinterface

// File: rtl/ip_codma_rd_watchdog.sv
// Cycle watchdog: counts enabled cycles since the last clear, flags expiry on the TIMEOUT-th cycle.
// Expire is combinational from the count; TIMEOUT=0 disables it. No backpressure.
module ip_codma_rd_watchdog #(
    parameter int TIMEOUT = 256
) (
    input  logic clk_i,
    input  logic reset_n_i,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    logic [WD_W-1:0] r_cnt;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_cnt <= '0;
        end else if (i_clr || !i_en) begin
            r_cnt <= '0;
        end else if (r_cnt != WD_W'(TIMEOUT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The cycle holding count TIMEOUT-1 is the TIMEOUT-th cycle spent waiting.
    assign o_expire = (TIMEOUT != 0) && i_en && !i_clr && (r_cnt == WD_W'(TIMEOUT - 1));

endmodule

// File: rtl/ip_codma_rd_engine.sv
// Read engine: takes an N-word command, requests the bus, packs beats LSB-first into a word buffer.
// start->bus_req 1 cycle, last beat->done_o 1 cycle; beats are never backpressured (always accepted in GRANTED).
module ip_codma_rd_engine
    import ip_codma_pkg::*;
#(
    parameter  int DATA_W    = 64,
    parameter  int WORD_W    = CODMA_WORD_W,
    parameter  int MAX_WORDS = 8,
    parameter  int TIMEOUT   = 256,
    localparam int CNT_W     = $clog2(MAX_WORDS + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic                               start_i,
    input  logic [CNT_W-1:0]                   words_i,
    input  logic                               stop_i,
    input  logic                               dma_error_i,
    ip_codma_rd_engine_if.master               bus,
    output logic [MAX_WORDS-1:0][WORD_W-1:0]   data_o,
    output logic                               done_o,
    output logic                               err_o,
    output logic                               busy_o,
    output rd_eng_state_t                      state_o
);

    localparam int BEAT_WORDS = beat_words(DATA_W, WORD_W);
    localparam int IDX_W      = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;

    rd_eng_state_t                      r_state;
    logic [CNT_W-1:0]                   r_tgt;
    logic [CNT_W-1:0]                   r_cnt;
    logic [MAX_WORDS-1:0][WORD_W-1:0]   r_data;
    logic                               r_done;
    logic                               r_err;
    logic                               r_req;

    logic                               w_beat;
    logic                               w_hard_err;
    logic                               w_wd_clr;
    logic                               w_wd_en;
    logic                               w_wd_expire;
    logic [CNT_W-1:0]                   w_remain;
    logic [CNT_W-1:0]                   w_take;
    logic [CNT_W-1:0]                   w_cnt_nxt;
    logic [BEAT_WORDS-1:0][IDX_W-1:0]   w_idx;
    logic [BEAT_WORDS-1:0]              w_wr;
    logic                               w_cmd_bad;

    assign w_beat     = (r_state == RD_GRANTED) && bus.bus_rvalid;
    assign w_hard_err = (r_state != RD_IDLE) && (bus.bus_error || dma_error_i);
    assign w_wd_en    = (r_state == RD_ASK) || (r_state == RD_GRANTED);
    assign w_wd_clr   = w_beat || ((r_state == RD_ASK) && bus.bus_grant);
    assign w_cmd_bad  = (words_i == '0) || (words_i > CNT_W'(MAX_WORDS));

    // Last beat may be partial: only the words still owed to the command are taken.
    assign w_remain  = r_tgt - r_cnt;
    assign w_take    = (w_remain > CNT_W'(BEAT_WORDS)) ? CNT_W'(BEAT_WORDS) : w_remain;
    assign w_cnt_nxt = r_cnt + w_take;

    always_comb begin
        w_idx = '0;
        w_wr  = '0;
        for (int b = 0; b < BEAT_WORDS; b++) begin
            w_idx[b] = IDX_W'(r_cnt + CNT_W'(b));
            w_wr[b]  = (CNT_W'(b) < w_take);
        end
    end

    ip_codma_rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_clr     (w_wd_clr),
        .i_en      (w_wd_en),
        .o_expire  (w_wd_expire)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= RD_IDLE;
            r_tgt   <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_req   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_hard_err) begin
                r_state <= RD_ERR;
                r_err   <= 1'b1;
                r_req   <= 1'b0;
            end else if (stop_i) begin
                r_state <= RD_IDLE;
                r_req   <= 1'b0;
            end else begin
                case (r_state)
                    RD_IDLE: begin
                        if (start_i) begin
                            if (w_cmd_bad) begin
                                r_state <= RD_ERR;
                                r_err   <= 1'b1;
                            end else begin
                                r_tgt   <= words_i;
                                r_cnt   <= '0;
                                r_err   <= 1'b0;
                                r_req   <= 1'b1;
                                r_state <= RD_ASK;
                            end
                        end
                    end
                    RD_ASK: begin
                        if (bus.bus_grant) begin
                            r_req   <= 1'b0;
                            r_state <= RD_GRANTED;
                        end else if (w_wd_expire) begin
                            r_req   <= 1'b0;
                            r_err   <= 1'b1;
                            r_state <= RD_ERR;
                        end
                    end
                    RD_GRANTED: begin
                        if (bus.bus_rvalid) begin
                            for (int b = 0; b < BEAT_WORDS; b++) begin
                                if (w_wr[b]) begin
                                    r_data[w_idx[b]] <= bus.bus_rdata[b*WORD_W +: WORD_W];
                                end
                            end
                            r_cnt <= w_cnt_nxt;
                            if (w_cnt_nxt == r_tgt) begin
                                r_done  <= 1'b1;
                                r_state <= RD_DONE;
                            end
                        end else if (w_wd_expire) begin
                            r_err   <= 1'b1;
                            r_state <= RD_ERR;
                        end
                    end
                    RD_DONE: r_state <= RD_IDLE;
                    RD_ERR:  r_state <= RD_IDLE;
                    default: r_state <= RD_IDLE;
                endcase
            end
        end
    end

    assign bus.bus_req = r_req;
    assign data_o      = r_data;
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign busy_o      = (r_state != RD_IDLE);
    assign state_o     = r_state;

endmodule
